// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 generator: latches one word on start, shifts it MSB-first
// through the polynomial feedback and reports the CRC with a one-cycle done pulse.
module crc8_serial #(
   parameter int         WIDTH = 8,
   parameter logic [7:0] POLY  = 8'h07,
   parameter logic [7:0] INIT  = 8'h00
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [7:0]       crc
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [7:0]       acc;
   logic [CW-1:0]    cnt;
   logic             fb;
   logic [7:0]       acc_nxt;

   always_comb begin
      fb      = acc[7] ^ sh[WIDTH-1];
      acc_nxt = {acc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         crc   <= 8'h00;
         cnt   <= '0;
         acc   <= INIT;
         sh    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sh    <= din;
                  acc   <= INIT;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc <= acc_nxt;
               sh  <= sh << 1;
               // cnt stops at the last index instead of wrapping
               if (cnt == LAST) begin
                  crc   <= acc_nxt;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
